// File: rtl/nrisc_stack_ctrl_if.sv
// rtl/nrisc_stack_ctrl_if.sv - request/acknowledge bus between NRISC_CORE and the call/return stack
interface nrisc_stack_ctrl_if #(
    parameter int TAM   = 16,
    parameter int DEPTH = 8
);
    localparam int SW = $clog2(DEPTH) + 1;

    logic           STACK_req;
    logic [1:0]     STACK_cmd;
    logic [TAM-1:0] STACK_PC_in;
    logic [2:0]     STACK_FLAGS_in;
    logic [TAM-1:0] STACK_OUT;
    logic [2:0]     STACK_FLAGS;
    logic           STACK_ack;
    logic           STACK_busy;
    logic           STACK_empty;
    logic           STACK_full;
    logic [SW-1:0]  STACK_depth;
    logic           STACK_ovf;
    logic           STACK_unf;

    modport master (
        output STACK_req, STACK_cmd, STACK_PC_in, STACK_FLAGS_in,
        input  STACK_OUT, STACK_FLAGS, STACK_ack, STACK_busy, STACK_empty,
               STACK_full, STACK_depth, STACK_ovf, STACK_unf
    );

    modport slave (
        input  STACK_req, STACK_cmd, STACK_PC_in, STACK_FLAGS_in,
        output STACK_OUT, STACK_FLAGS, STACK_ack, STACK_busy, STACK_empty,
               STACK_full, STACK_depth, STACK_ovf, STACK_unf
    );
endinterface

// File: rtl/nrisc_stack_ctrl.sv
// rtl/nrisc_stack_ctrl.sv - call/return LIFO saving PC and ULA flags for NRISC
module nrisc_stack_ctrl #(
    parameter int TAM   = 16,
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    nrisc_stack_ctrl_if.slave  s
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = AW + 1;
    localparam int EW = TAM + 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PUSH_WR = 3'd1,
        POP_RD  = 3'd2,
        POP_OUT = 3'd3,
        CLR     = 3'd4
    } state_t;

    state_t         state, state_nxt;
    logic [SW-1:0]  sp;
    logic [SW-1:0]  sp_dec;
    logic [EW-1:0]  mem [DEPTH];
    logic [EW-1:0]  op_q;
    logic [EW-1:0]  rd_q;
    logic [TAM-1:0] out_q;
    logic [2:0]     flags_q;
    logic           ack_q, ovf_q, unf_q;
    logic           full, empty;

    logic accept, wr_en, rd_en, clr_en, out_en, ovf_set, unf_set, ack_nxt;

    assign full   = (sp == SW'(DEPTH));
    assign empty  = (sp == '0);
    assign sp_dec = sp - SW'(1);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        clr_en    = 1'b0;
        out_en    = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        ack_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (s.STACK_req) begin
                    accept = 1'b1;
                    case (s.STACK_cmd)
                        2'b01:   state_nxt = PUSH_WR;
                        2'b10:   state_nxt = POP_RD;
                        2'b11:   state_nxt = CLR;
                        default: state_nxt = IDLE;
                    endcase
                end
            end
            PUSH_WR: begin
                ack_nxt   = 1'b1;
                state_nxt = IDLE;
                if (full) ovf_set = 1'b1;
                else      wr_en   = 1'b1;
            end
            POP_RD: begin
                if (empty) begin
                    unf_set   = 1'b1;
                    ack_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    rd_en     = 1'b1;
                    state_nxt = POP_OUT;
                end
            end
            POP_OUT: begin
                out_en    = 1'b1;
                ack_nxt   = 1'b1;
                state_nxt = IDLE;
            end
            CLR: begin
                clr_en    = 1'b1;
                ack_nxt   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sp      <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            out_q   <= '0;
            flags_q <= '0;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            ack_q <= ack_nxt;
            if (accept) op_q <= {s.STACK_PC_in, s.STACK_FLAGS_in};
            if (wr_en)  sp   <= sp + SW'(1);
            if (rd_en) begin
                rd_q <= mem[sp_dec[AW-1:0]];
                sp   <= sp_dec;
            end
            if (out_en) {out_q, flags_q} <= rd_q;
            if (ovf_set) ovf_q <= 1'b1;
            if (unf_set) unf_q <= 1'b1;
            if (clr_en) begin
                sp    <= '0;
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end
        end
    end

    // Storage is deliberately left out of reset; only the write strobe respects rst.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[sp[AW-1:0]] <= op_q;
    end

    assign s.STACK_OUT   = out_q;
    assign s.STACK_FLAGS = flags_q;
    assign s.STACK_ack   = ack_q;
    assign s.STACK_busy  = (state != IDLE);
    assign s.STACK_empty = empty;
    assign s.STACK_full  = full;
    assign s.STACK_depth = sp;
    assign s.STACK_ovf   = ovf_q;
    assign s.STACK_unf   = unf_q;
endmodule

// File: tb/tb_nrisc_stack_ctrl.sv
// tb/tb_nrisc_stack_ctrl.sv - randomized self-checking bench for nrisc_stack_ctrl
module tb_nrisc_stack_ctrl;
    localparam int TAM   = 16;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    nrisc_stack_ctrl_if #(.TAM(TAM), .DEPTH(DEPTH)) s ();
    nrisc_stack_ctrl #(.TAM(TAM), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .s(s));

    // Reference: a bounded queue of {pc, flags} plus sticky error bits and the last popped entry.
    logic [18:0] mq[$];
    bit          m_ovf, m_unf;
    logic [15:0] m_pc;
    logic [2:0]  m_fl;

    task automatic model_reset();
        mq.delete();
        m_ovf = 0; m_unf = 0; m_pc = '0; m_fl = '0;
    endtask

    task automatic model_apply(input logic [1:0] c, input logic [15:0] pc, input logic [2:0] fl,
                               output int elat);
        elat = 0;
        case (c)
            2'b01: begin
                if (mq.size() < DEPTH) mq.push_back({pc, fl});
                else m_ovf = 1;
                elat = 1;
            end
            2'b10: begin
                if (mq.size() > 0) begin
                    {m_pc, m_fl} = mq.pop_back();
                    elat = 2;
                end else begin
                    m_unf = 1;
                    elat = 1;
                end
            end
            2'b11: begin
                mq.delete();
                m_ovf = 0; m_unf = 0;
                elat = 1;
            end
            default: elat = 0;
        endcase
    endtask

    // Called #1 after a posedge; returns cycles from accept edge to ack (0 = none within bound).
    task automatic run_op(input logic [1:0] c, input logic [15:0] pc, input logic [2:0] fl,
                          output int elat, output int lat, output int dep1, output logic busy0);
        model_apply(c, pc, fl, elat);
        s.STACK_req = 1'b1; s.STACK_cmd = c; s.STACK_PC_in = pc; s.STACK_FLAGS_in = fl;
        @(posedge clk); #1;
        s.STACK_req = 1'b0;
        busy0 = s.STACK_busy;
        lat = 0; dep1 = -1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 1) dep1 = int'(s.STACK_depth);
            if (s.STACK_ack === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s.STACK_req = 1'b0; s.STACK_cmd = 2'b00; s.STACK_PC_in = '0; s.STACK_FLAGS_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        checks++; if (s.STACK_OUT !== 16'h0) begin failures++; $display("FAIL reset_out got=%h exp=0000", s.STACK_OUT); end
        checks++; if (s.STACK_FLAGS !== 3'b0) begin failures++; $display("FAIL reset_flags got=%b exp=000", s.STACK_FLAGS); end
        checks++; if (s.STACK_depth !== 4'd0) begin failures++; $display("FAIL reset_depth got=%0d exp=0", s.STACK_depth); end
        checks++; if ({s.STACK_empty, s.STACK_full} !== 2'b10) begin failures++; $display("FAIL reset_empty_full got=%b exp=10", {s.STACK_empty, s.STACK_full}); end
        checks++; if ({s.STACK_ack, s.STACK_busy, s.STACK_ovf, s.STACK_unf} !== 4'b0) begin failures++; $display("FAIL reset_ctl got=%b exp=0000", {s.STACK_ack, s.STACK_busy, s.STACK_ovf, s.STACK_unf}); end
        @(posedge clk); #1;
        checks++; if (s.STACK_ack !== 1'b0) begin failures++; $display("FAIL reset_noack got=%b exp=0", s.STACK_ack); end
    endtask

    task automatic test_lifo();
        logic [15:0] pcs [3] = '{16'h0010, 16'h0020, 16'h0030};
        logic [2:0]  fls [3] = '{3'b001, 3'b010, 3'b100};
        int elat, lat, dep1;
        logic busy0;
        for (int i = 0; i < 3; i++) begin
            run_op(2'b01, pcs[i], fls[i], elat, lat, dep1, busy0);
            checks++; if (lat != 1) begin failures++; $display("FAIL lifo_push_lat got=%0d exp=1", lat); end
            checks++; if (dep1 != i + 1) begin failures++; $display("FAIL lifo_push_depth got=%0d exp=%0d", dep1, i + 1); end
        end
        for (int i = 2; i >= 0; i--) begin
            run_op(2'b10, 16'h0, 3'b0, elat, lat, dep1, busy0);
            checks++; if (lat != 2) begin failures++; $display("FAIL lifo_pop_lat got=%0d exp=2", lat); end
            checks++; if (dep1 != i) begin failures++; $display("FAIL lifo_pop_depth got=%0d exp=%0d", dep1, i); end
            checks++; if ({s.STACK_OUT, s.STACK_FLAGS} !== {pcs[i], fls[i]}) begin failures++; $display("FAIL lifo_pop_data got=%h/%b exp=%h/%b", s.STACK_OUT, s.STACK_FLAGS, pcs[i], fls[i]); end
        end
    endtask

    task automatic test_overflow();
        int elat, lat, dep1;
        logic busy0;
        for (int i = 0; i < DEPTH; i++) run_op(2'b01, 16'h0100 + 16'(i), 3'(i), elat, lat, dep1, busy0);
        checks++; if (s.STACK_full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", s.STACK_full); end
        run_op(2'b01, 16'hBEEF, 3'b111, elat, lat, dep1, busy0);
        checks++; if (lat != 1) begin failures++; $display("FAIL ovf_lat got=%0d exp=1", lat); end
        checks++; if (s.STACK_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", s.STACK_ovf); end
        checks++; if (dep1 != DEPTH) begin failures++; $display("FAIL ovf_depth got=%0d exp=%0d", dep1, DEPTH); end
        run_op(2'b10, 16'h0, 3'b0, elat, lat, dep1, busy0);
        checks++; if (s.STACK_OUT !== 16'h0107) begin failures++; $display("FAIL ovf_pop got=%h exp=0107", s.STACK_OUT); end
        checks++; if (s.STACK_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", s.STACK_ovf); end
        run_op(2'b11, 16'h0, 3'b0, elat, lat, dep1, busy0);
    endtask

    task automatic test_underflow_clear();
        int elat, lat, dep1;
        logic busy0;
        logic [15:0] prev_out;
        prev_out = s.STACK_OUT;
        run_op(2'b10, 16'h0, 3'b0, elat, lat, dep1, busy0);
        checks++; if (lat != 1) begin failures++; $display("FAIL unf_lat got=%0d exp=1", lat); end
        checks++; if (s.STACK_unf !== 1'b1) begin failures++; $display("FAIL unf_flag got=%b exp=1", s.STACK_unf); end
        checks++; if (s.STACK_OUT !== prev_out) begin failures++; $display("FAIL unf_out got=%h exp=%h", s.STACK_OUT, prev_out); end
        run_op(2'b11, 16'h0, 3'b0, elat, lat, dep1, busy0);
        checks++; if (lat != 1) begin failures++; $display("FAIL clr_lat got=%0d exp=1", lat); end
        checks++; if ({s.STACK_unf, s.STACK_ovf} !== 2'b00) begin failures++; $display("FAIL clr_flags got=%b exp=00", {s.STACK_unf, s.STACK_ovf}); end
        checks++; if (dep1 != 0) begin failures++; $display("FAIL clr_depth got=%0d exp=0", dep1); end
    endtask

    task automatic test_busy_ignore();
        int elat, lat, dep1;
        logic busy0;
        run_op(2'b01, 16'h1111, 3'b001, elat, lat, dep1, busy0);
        run_op(2'b01, 16'h2222, 3'b010, elat, lat, dep1, busy0);
        s.STACK_req = 1'b1; s.STACK_cmd = 2'b10;
        @(posedge clk); #1;
        s.STACK_cmd = 2'b01; s.STACK_PC_in = 16'h5555; s.STACK_FLAGS_in = 3'b101;
        @(posedge clk); #1;
        checks++; if ({s.STACK_ack, s.STACK_depth} !== {1'b0, 4'd1}) begin failures++; $display("FAIL busy_e1 got=%b/%0d exp=0/1", s.STACK_ack, s.STACK_depth); end
        @(posedge clk); #1;
        checks++; if ({s.STACK_ack, s.STACK_depth, s.STACK_OUT} !== {1'b1, 4'd1, 16'h2222}) begin failures++; $display("FAIL busy_e2 got=%b/%0d/%h exp=1/1/2222", s.STACK_ack, s.STACK_depth, s.STACK_OUT); end
        @(posedge clk); #1;
        s.STACK_req = 1'b0;
        checks++; if ({s.STACK_busy, s.STACK_ack} !== 2'b10) begin failures++; $display("FAIL busy_e3 got=%b exp=10", {s.STACK_busy, s.STACK_ack}); end
        @(posedge clk); #1;
        checks++; if ({s.STACK_ack, s.STACK_depth} !== {1'b1, 4'd2}) begin failures++; $display("FAIL busy_e4 got=%b/%0d exp=1/2", s.STACK_ack, s.STACK_depth); end
        model_apply(2'b10, 16'h0, 3'b0, elat);
        model_apply(2'b01, 16'h5555, 3'b101, elat);
        @(posedge clk); #1;
        checks++; if ({s.STACK_ack, s.STACK_busy, s.STACK_depth} !== {2'b00, 4'd2}) begin failures++; $display("FAIL busy_single got=%b/%b/%0d exp=0/0/2", s.STACK_ack, s.STACK_busy, s.STACK_depth); end
        run_op(2'b10, 16'h0, 3'b0, elat, lat, dep1, busy0);
        checks++; if ({s.STACK_OUT, s.STACK_FLAGS} !== {16'h5555, 3'b101}) begin failures++; $display("FAIL busy_pop got=%h/%b exp=5555/101", s.STACK_OUT, s.STACK_FLAGS); end
    endtask

    task automatic test_reset_mid();
        int elat, lat, dep1;
        logic busy0;
        run_op(2'b11, 16'h0, 3'b0, elat, lat, dep1, busy0);
        run_op(2'b01, 16'hA0A0, 3'b011, elat, lat, dep1, busy0);
        run_op(2'b01, 16'hB0B0, 3'b110, elat, lat, dep1, busy0);
        s.STACK_req = 1'b1; s.STACK_cmd = 2'b10;
        @(posedge clk); #1;
        s.STACK_req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        checks++; if ({s.STACK_ack, s.STACK_busy} !== 2'b00) begin failures++; $display("FAIL rstmid_ctl got=%b exp=00", {s.STACK_ack, s.STACK_busy}); end
        checks++; if ({s.STACK_OUT, s.STACK_FLAGS} !== 19'h0) begin failures++; $display("FAIL rstmid_out got=%h/%b exp=0000/000", s.STACK_OUT, s.STACK_FLAGS); end
        checks++; if ({s.STACK_depth, s.STACK_empty} !== {4'd0, 1'b1}) begin failures++; $display("FAIL rstmid_depth got=%0d/%b exp=0/1", s.STACK_depth, s.STACK_empty); end
        @(posedge clk); #1;
        checks++; if (s.STACK_ack !== 1'b0) begin failures++; $display("FAIL rstmid_noack got=%b exp=0", s.STACK_ack); end
        run_op(2'b10, 16'h0, 3'b0, elat, lat, dep1, busy0);
        checks++; if ({s.STACK_unf, 4'(lat)} !== {1'b1, 4'd1}) begin failures++; $display("FAIL rstmid_unf got=%b/%0d exp=1/1", s.STACK_unf, lat); end
    endtask

    task automatic test_random();
        int elat, lat, dep1, r;
        logic busy0;
        logic [1:0] c;
        logic [15:0] pc;
        logic [2:0] fl;
        for (int n = 0; n < 120; n++) begin
            r  = int'($urandom_range(99));
            c  = (r < 45) ? 2'b01 : (r < 82) ? 2'b10 : (r < 90) ? 2'b11 : 2'b00;
            pc = 16'($urandom);
            fl = 3'($urandom);
            run_op(c, pc, fl, elat, lat, dep1, busy0);
            checks++; if (lat != elat) begin failures++; $display("FAIL rnd_lat op=%0d cmd=%0d got=%0d exp=%0d", n, c, lat, elat); end
            checks++; if (dep1 != mq.size()) begin failures++; $display("FAIL rnd_depth op=%0d got=%0d exp=%0d", n, dep1, mq.size()); end
            checks++; if (busy0 !== (c != 2'b00)) begin failures++; $display("FAIL rnd_busy op=%0d got=%b exp=%b", n, busy0, c != 2'b00); end
            checks++; if ({s.STACK_OUT, s.STACK_FLAGS} !== {m_pc, m_fl}) begin failures++; $display("FAIL rnd_out op=%0d got=%h/%b exp=%h/%b", n, s.STACK_OUT, s.STACK_FLAGS, m_pc, m_fl); end
            checks++; if ({s.STACK_ovf, s.STACK_unf} !== {m_ovf, m_unf}) begin failures++; $display("FAIL rnd_err op=%0d got=%b%b exp=%b%b", n, s.STACK_ovf, s.STACK_unf, m_ovf, m_unf); end
            checks++; if ({s.STACK_full, s.STACK_empty} !== {mq.size() == DEPTH, mq.size() == 0}) begin failures++; $display("FAIL rnd_fe op=%0d got=%b%b exp=%b%b", n, s.STACK_full, s.STACK_empty, mq.size() == DEPTH, mq.size() == 0); end
        end
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_overflow();
        test_underflow_clear();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
